// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU core: scheduler state encoding and the
// instruction opcodes the decoder and scheduler agree on.
package gpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_REQUEST = 3'd3,
    ST_WAIT    = 3'd4,
    ST_EXECUTE = 3'd5,
    ST_UPDATE  = 3'd6,
    ST_DONE    = 3'd7
  } core_state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_BRNZP = 4'h1;
  localparam logic [3:0] OP_CMP   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_MUL   = 4'h5;
  localparam logic [3:0] OP_DIV   = 4'h6;
  localparam logic [3:0] OP_LDR   = 4'h7;
  localparam logic [3:0] OP_STR   = 4'h8;
  localparam logic [3:0] OP_CONST = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/core_scheduler_if.sv
// Bundle between the core scheduler and its neighbours (dispatcher, fetcher,
// decoder, LSUs). master = scheduler side, slave = environment side.
interface core_scheduler_if #(
  parameter int THREADS = 4,
  parameter int PC_W    = 8
);
  import gpu_pkg::*;

  logic               start;
  logic [THREADS-1:0] thread_mask;
  logic               fetch_req;
  logic [PC_W-1:0]    fetch_pc;
  logic               fetch_valid;
  logic [15:0]        fetch_instr;
  logic [15:0]        instr;
  logic               is_ldr;
  logic               is_str;
  logic               is_branch;
  logic               is_cmp;
  logic               is_halt;
  logic               rd_write;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               lsu_req;
  logic [THREADS-1:0] lsu_done;
  logic               reg_we;
  logic               nzp_we;
  core_state_t        core_state;
  logic               done;

  modport master (
    input  start, thread_mask, fetch_valid, fetch_instr,
    input  is_ldr, is_str, is_branch, is_cmp, is_halt, rd_write,
    input  branch_taken, branch_target, lsu_done,
    output fetch_req, fetch_pc, instr, lsu_req, reg_we, nzp_we, core_state, done
  );

  modport slave (
    output start, thread_mask, fetch_valid, fetch_instr,
    output is_ldr, is_str, is_branch, is_cmp, is_halt, rd_write,
    output branch_taken, branch_target, lsu_done,
    input  fetch_req, fetch_pc, instr, lsu_req, reg_we, nzp_we, core_state, done
  );
endinterface

// File: rtl/core_scheduler_lsu_join.sv
// Joins per-thread LSU completion pulses: sticky accumulator against the
// thread mask captured when the memory request is issued.
module lsu_join #(
  parameter int THREADS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               accumulate,
  input  logic [THREADS-1:0] thread_mask,
  input  logic [THREADS-1:0] lsu_done,
  output logic               all_done
);

  logic [THREADS-1:0] done_acc_r;
  logic [THREADS-1:0] mask_r;
  logic               all_done_r;

  // Accumulator, captured mask and registered join flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_acc_r <= {THREADS{1'b0}};
      mask_r     <= {THREADS{1'b0}};
      all_done_r <= 1'b0;
    end else if (clear) begin
      done_acc_r <= {THREADS{1'b0}};
      mask_r     <= thread_mask;
      // An empty mask is already joined, so WAIT exits after its first cycle.
      all_done_r <= (thread_mask == {THREADS{1'b0}});
    end else if (accumulate) begin
      done_acc_r <= done_acc_r | lsu_done;
      all_done_r <= (((done_acc_r | lsu_done) & mask_r) == mask_r);
    end else begin
      done_acc_r <= done_acc_r;
      mask_r     <= mask_r;
      all_done_r <= all_done_r;
    end
  end

  // Drive the join flag from its register
  always_comb begin
    all_done = all_done_r;
  end

endmodule

// File: rtl/core_scheduler.sv
// Per-core control FSM: sequences one thread block through fetch, decode,
// memory request/wait, execute and writeback; owns the shared PC.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int PC_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  core_scheduler_if.master bus
);

  core_state_t     state_r;
  logic [PC_W-1:0] pc_r;
  logic [15:0]     instr_r;
  logic            fetch_req_r;
  logic            lsu_req_r;
  logic            reg_we_r;
  logic            nzp_we_r;
  logic            done_r;
  logic            mem_op_s;
  logic            join_clear_s;
  logic            join_acc_s;
  logic            all_done_s;

  // Decoder-derived memory flag and lsu_join control
  always_comb begin
    mem_op_s     = bus.is_ldr | bus.is_str;
    join_clear_s = (state_r == ST_REQUEST) && mem_op_s;
    join_acc_s   = (state_r == ST_WAIT);
  end

  lsu_join #(.THREADS(THREADS)) u_lsu_join (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (join_clear_s),
    .accumulate  (join_acc_s),
    .thread_mask (bus.thread_mask),
    .lsu_done    (bus.lsu_done),
    .all_done    (all_done_s)
  );

  // Main FSM; pulse outputs are set on the edge entering their state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pc_r        <= {PC_W{1'b0}};
      instr_r     <= 16'h0000;
      fetch_req_r <= 1'b0;
      lsu_req_r   <= 1'b0;
      reg_we_r    <= 1'b0;
      nzp_we_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      lsu_req_r <= 1'b0;
      reg_we_r  <= 1'b0;
      nzp_we_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r     <= ST_FETCH;
            pc_r        <= {PC_W{1'b0}};
            fetch_req_r <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.fetch_valid) begin
            instr_r     <= bus.fetch_instr;
            fetch_req_r <= 1'b0;
            state_r     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          lsu_req_r <= mem_op_s;
          state_r   <= ST_REQUEST;
        end
        ST_REQUEST: begin
          state_r <= mem_op_s ? ST_WAIT : ST_EXECUTE;
        end
        ST_WAIT: begin
          if (all_done_s) begin
            state_r <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          reg_we_r <= bus.rd_write & ~bus.is_halt;
          nzp_we_r <= bus.is_cmp & ~bus.is_halt;
          state_r  <= ST_UPDATE;
        end
        ST_UPDATE: begin
          if (bus.is_halt) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            pc_r        <= (bus.is_branch && bus.branch_taken) ? bus.branch_target
                                                               : pc_r + PC_W'(1);
            fetch_req_r <= 1'b1;
            state_r     <= ST_FETCH;
          end
        end
        ST_DONE: begin
          if (!bus.start) begin
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          fetch_req_r <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  // Drive interface outputs straight from registers
  always_comb begin
    bus.fetch_req  = fetch_req_r;
    bus.fetch_pc   = pc_r;
    bus.instr      = instr_r;
    bus.lsu_req    = lsu_req_r;
    bus.reg_we     = reg_we_r;
    bus.nzp_we     = nzp_we_r;
    bus.core_state = state_r;
    bus.done       = done_r;
  end

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: the bench plays fetcher, decoder, LSUs
// and dispatcher, and checks each scenario against hand-derived values.
module tb_core_scheduler;
  import gpu_pkg::*;

  logic clk;
  logic rst_n;
  logic auto_fetch;
  logic [15:0] prog [256];
  logic taken_at [256];
  int n_tests;
  int n_fail;
  int lsu_req_cnt;
  logic [3:0] op;

  core_scheduler_if #(.THREADS(4), .PC_W(8)) bus ();

  core_scheduler #(.THREADS(4), .PC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side fetcher and decoder
  assign op                = opcode_of(bus.instr);
  assign bus.fetch_valid   = auto_fetch;
  assign bus.fetch_instr   = prog[bus.fetch_pc];
  assign bus.is_ldr        = (op == OP_LDR);
  assign bus.is_str        = (op == OP_STR);
  assign bus.is_branch     = (op == OP_BRNZP);
  assign bus.is_cmp        = (op == OP_CMP);
  assign bus.is_halt       = (op == OP_HALT);
  assign bus.rd_write      = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
                             (op == OP_DIV) || (op == OP_LDR) || (op == OP_CONST);
  assign bus.branch_taken  = taken_at[bus.fetch_pc];
  assign bus.branch_target = bus.instr[7:0];

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.lsu_req === 1'b1) lsu_req_cnt++;
  endtask

  task automatic reset_dut();
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.thread_mask = 4'b0000;
    bus.lsu_done    = 4'b0000;
    auto_fetch      = 1'b1;
    for (int a = 0; a < 256; a++) begin
      prog[a]     = 16'hF000;
      taken_at[a] = 1'b0;
    end
    tick();
    tick();
    rst_n       = 1'b1;
    lsu_req_cnt = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (bus.core_state !== ST_IDLE || bus.fetch_req !== 1'b0 || bus.fetch_pc !== 8'h00 ||
        bus.instr !== 16'h0000 || bus.lsu_req !== 1'b0 || bus.reg_we !== 1'b0 ||
        bus.nzp_we !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d freq=%b pc=%h instr=%h lsu=%b rwe=%b nwe=%b done=%b expected all zero",
               bus.core_state, bus.fetch_req, bus.fetch_pc, bus.instr, bus.lsu_req,
               bus.reg_we, bus.nzp_we, bus.done);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.core_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL idle_no_start: got %0d expected %0d", bus.core_state, ST_IDLE);
    end
  endtask

  task automatic test_reset_mid_wait();
    reset_dut();
    prog[0]         = 16'h7000;
    bus.thread_mask = 4'b1111;
    bus.start       = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (bus.core_state !== ST_WAIT) begin
      n_fail++;
      $display("FAIL midwait_reach: got %0d expected %0d", bus.core_state, ST_WAIT);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.core_state !== ST_IDLE || bus.fetch_pc !== 8'h00 || bus.lsu_req !== 1'b0 ||
        bus.done !== 1'b0 || bus.instr !== 16'h0000) begin
      n_fail++;
      $display("FAIL midwait_async_reset: got st=%0d pc=%h lsu=%b done=%b instr=%h expected 0/00/0/0/0000",
               bus.core_state, bus.fetch_pc, bus.lsu_req, bus.done, bus.instr);
    end
    bus.start = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (bus.core_state !== ST_IDLE || bus.fetch_req !== 1'b0 || lsu_req_cnt != 1) begin
      n_fail++;
      $display("FAIL midwait_after_reset: got st=%0d freq=%b lsu_pulses=%0d expected 0/0/1",
               bus.core_state, bus.fetch_req, lsu_req_cnt);
    end
  endtask

  task automatic test_add_halt();
    core_state_t exp_st;
    reset_dut();
    prog[0]   = 16'h3000;
    prog[1]   = 16'hF000;
    bus.start = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      case ((i - 1) % 5)
        0:       exp_st = ST_FETCH;
        1:       exp_st = ST_DECODE;
        2:       exp_st = ST_REQUEST;
        3:       exp_st = ST_EXECUTE;
        default: exp_st = ST_UPDATE;
      endcase
      if (i == 11) exp_st = ST_DONE;
      n_tests++;
      if (bus.core_state !== exp_st || bus.reg_we !== (i == 5) || bus.done !== (i == 11) ||
          bus.nzp_we !== 1'b0) begin
        n_fail++;
        $display("FAIL add_halt cyc %0d: got st=%0d rwe=%b done=%b nwe=%b expected st=%0d rwe=%b done=%b nwe=0",
                 i, bus.core_state, bus.reg_we, bus.done, bus.nzp_we, exp_st, (i == 5), (i == 11));
      end
    end
    n_tests++;
    if (bus.fetch_pc !== 8'h01 || lsu_req_cnt != 0) begin
      n_fail++;
      $display("FAIL add_halt_pc: got pc=%h lsu_pulses=%0d expected 01/0", bus.fetch_pc, lsu_req_cnt);
    end
  endtask

  task automatic test_ldr_join();
    logic [3:0] pulses [4];
    pulses[0] = 4'b0010;
    pulses[1] = 4'b0001;
    pulses[2] = 4'b0100;
    pulses[3] = 4'b1000;
    reset_dut();
    prog[0]         = 16'h7000;
    bus.thread_mask = 4'b1011;
    bus.start       = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (bus.lsu_req !== (i == 3)) begin
        n_fail++;
        $display("FAIL ldr_lsu_req cyc %0d: got %b expected %b", i, bus.lsu_req, (i == 3));
      end
    end
    bus.thread_mask = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      bus.lsu_done = pulses[p];
      tick();
      bus.lsu_done = 4'b0000;
      n_tests++;
      if (bus.core_state !== ST_WAIT) begin
        n_fail++;
        $display("FAIL ldr_wait pulse %0d: got %0d expected %0d", p, bus.core_state, ST_WAIT);
      end
    end
    tick();
    n_tests++;
    if (bus.core_state !== ST_EXECUTE) begin
      n_fail++;
      $display("FAIL ldr_exit: got %0d expected %0d", bus.core_state, ST_EXECUTE);
    end
    tick();
    n_tests++;
    if (bus.core_state !== ST_UPDATE || bus.reg_we !== 1'b1) begin
      n_fail++;
      $display("FAIL ldr_update: got st=%0d rwe=%b expected %0d/1", bus.core_state, bus.reg_we, ST_UPDATE);
    end
    for (int i = 0; i < 6; i++) tick();
    n_tests++;
    if (bus.done !== 1'b1 || lsu_req_cnt != 1) begin
      n_fail++;
      $display("FAIL ldr_single_req: got done=%b lsu_pulses=%0d expected 1/1", bus.done, lsu_req_cnt);
    end
  endtask

  task automatic test_branch_wrap();
    reset_dut();
    prog[8'h00]     = 16'h1E20;
    taken_at[8'h00] = 1'b1;
    prog[8'h20]     = 16'h1E40;
    prog[8'h21]     = 16'h1EFF;
    taken_at[8'h21] = 1'b1;
    prog[8'hFF]     = 16'h9000;
    bus.start       = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 5 || i == 20) begin
        n_tests++;
        if (bus.reg_we !== (i == 20)) begin
          n_fail++;
          $display("FAIL branch_reg_we cyc %0d: got %b expected %b", i, bus.reg_we, (i == 20));
        end
      end
      if (i == 6 || i == 11 || i == 16 || i == 21) begin
        n_tests++;
        if (bus.fetch_pc !== (i == 6 ? 8'h20 : i == 11 ? 8'h21 : i == 16 ? 8'hFF : 8'h00) ||
            bus.fetch_req !== 1'b1) begin
          n_fail++;
          $display("FAIL branch_pc cyc %0d: got pc=%h freq=%b expected pc=%h freq=1", i, bus.fetch_pc,
                   bus.fetch_req, (i == 6 ? 8'h20 : i == 11 ? 8'h21 : i == 16 ? 8'hFF : 8'h00));
        end
      end
    end
  endtask

  task automatic test_fetch_stall();
    reset_dut();
    prog[0]    = 16'hF000;
    auto_fetch = 1'b0;
    bus.start  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (bus.core_state !== ST_FETCH || bus.fetch_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_stall: got st=%0d freq=%b expected %0d/1", bus.core_state, bus.fetch_req, ST_FETCH);
    end
    auto_fetch = 1'b1;
    tick();
    n_tests++;
    if (bus.core_state !== ST_DECODE || bus.fetch_req !== 1'b0 || bus.instr !== 16'hF000) begin
      n_fail++;
      $display("FAIL fetch_accept: got st=%0d freq=%b instr=%h expected %0d/0/f000",
               bus.core_state, bus.fetch_req, bus.instr, ST_DECODE);
    end
  endtask

  task automatic test_str_nomask_done();
    reset_dut();
    prog[0]         = 16'h8000;
    prog[1]         = 16'h2000;
    prog[2]         = 16'hF000;
    bus.thread_mask = 4'b0000;
    bus.start       = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 4 || i == 5) begin
        n_tests++;
        if (bus.core_state !== (i == 4 ? ST_WAIT : ST_EXECUTE)) begin
          n_fail++;
          $display("FAIL str_wait cyc %0d: got %0d expected %0d", i, bus.core_state,
                   (i == 4 ? ST_WAIT : ST_EXECUTE));
        end
      end
      if (i == 6 || i == 11) begin
        n_tests++;
        if (bus.reg_we !== 1'b0 || bus.nzp_we !== (i == 11)) begin
          n_fail++;
          $display("FAIL str_cmp_we cyc %0d: got rwe=%b nwe=%b expected 0/%b", i, bus.reg_we,
                   bus.nzp_we, (i == 11));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bus.done !== 1'b1 || bus.core_state !== ST_DONE) begin
        n_fail++;
        $display("FAIL done_hold %0d: got done=%b st=%0d expected 1/%0d", i, bus.done, bus.core_state, ST_DONE);
      end
      tick();
    end
    bus.start = 1'b0;
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.core_state !== ST_IDLE || lsu_req_cnt != 1) begin
      n_fail++;
      $display("FAIL done_release: got done=%b st=%0d lsu_pulses=%0d expected 0/%0d/1",
               bus.done, bus.core_state, lsu_req_cnt, ST_IDLE);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    lsu_req_cnt = 0;
    rst_n       = 1'b0;
    test_reset();
    test_reset_mid_wait();
    test_add_halt();
    test_ldr_join();
    test_branch_wrap();
    test_fetch_stall();
    test_str_nomask_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
